// File: rtl/seg_display_scheduler.sv
// +----------------------------------------------------------------------------+
// | seg_display_scheduler: pages CPU debug values onto an 8-digit 7-seg display |
// | Optional build macro: SEG_DP_PAGE_EN (decimal point marks the page number)  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_display_scheduler #(
  parameter int SCAN_DIV   = 100_000,
  parameter int PAGE_TICKS = 2_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_auto_rotate,
  input  logic        i_page_next,
  input  logic        i_halt,
  input  logic [7:0]  i_max_addr,
  input  logic [15:0] i_alu_P,
  input  logic [15:0] i_alu_Q,
  input  logic [15:0] i_result_high,
  input  logic [15:0] i_result_low,
  input  logic [2:0]  i_alu_op,
  output logic [7:0]  o_seg_an,
  output logic [7:0]  o_seg_cat,
  output logic [1:0]  o_page
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PG_W   = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;

  typedef enum logic [1:0] {
    PG0 = 2'd0,
    PG1 = 2'd1,
    PG2 = 2'd2
  } page_e;

  logic [SCAN_W-1:0] r_scan_cnt;
  logic [2:0]        r_idx;
  logic [7:0]        r_an;
  logic [7:0]        r_cat;
  logic [15:0]       r_sh_p;
  logic [15:0]       r_sh_q;
  logic [15:0]       r_sh_hi;
  logic [15:0]       r_sh_lo;
  logic [7:0]        r_sh_addr;
  logic [2:0]        r_sh_op;

  page_e             r_page;
  logic [PG_W-1:0]   r_page_cnt;
  logic              r_halt_lock;
  logic              r_halt_d;

  logic              w_tick;
  logic              w_halt_rise;
  logic [31:0]       w_word;
  logic [3:0]        w_nib;
  logic              w_blank;
  logic [6:0]        w_seg;
  logic              w_dp;

  assign w_tick      = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign w_halt_rise = i_halt & ~r_halt_d;

  function automatic page_e f_next(input page_e p);
    case (p)
      PG0:     return PG1;
      PG1:     return PG2;
      default: return PG0;
    endcase
  endfunction

  // Each page is laid out as 8 nibbles, digit k taken from bits [4k+3:4k].
  always_comb begin
    w_word  = 32'h0;
    w_blank = 1'b0;
    case (r_page)
      PG0: w_word = {r_sh_p, r_sh_q};
      PG1: w_word = {r_sh_hi, r_sh_lo};
      PG2: begin
        w_word  = {r_sh_addr, 4'h0, 1'b0, r_sh_op, 16'h0000};
        w_blank = (r_idx == 3'd5) || (r_idx < 3'd4);
      end
      default: w_blank = 1'b1;
    endcase
    w_nib = w_word[r_idx*4 +: 4];
  end

  always_comb begin
    w_seg = 7'h7F;
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      default: w_seg = 7'h0E;
    endcase
  end

`ifdef SEG_DP_PAGE_EN
  assign w_dp = ~(((r_page == PG1) && (r_idx == 3'd0)) ||
                  ((r_page == PG2) && (r_idx == 3'd1)));
`else
  assign w_dp = 1'b1;
`endif

  // Outputs load the digit under r_idx at the tick; shadows refresh as digit 7 goes out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= 3'd0;
      r_an       <= 8'hFF;
      r_cat      <= 8'hFF;
      r_sh_p     <= 16'h0;
      r_sh_q     <= 16'h0;
      r_sh_hi    <= 16'h0;
      r_sh_lo    <= 16'h0;
      r_sh_addr  <= 8'h0;
      r_sh_op    <= 3'h0;
    end else if (w_tick) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 3'd1;
      r_an       <= ~(8'h01 << r_idx);
      r_cat      <= {w_dp, (w_blank ? 7'h7F : w_seg)};
      if (r_idx == 3'd7) begin
        r_sh_p    <= i_alu_P;
        r_sh_q    <= i_alu_Q;
        r_sh_hi   <= i_result_high;
        r_sh_lo   <= i_result_low;
        r_sh_addr <= i_max_addr;
        r_sh_op   <= i_alu_op;
      end
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Priority: halt rising edge, then manual advance, then auto rotation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_page      <= PG0;
      r_page_cnt  <= '0;
      r_halt_lock <= 1'b0;
      r_halt_d    <= 1'b0;
    end else begin
      r_halt_d <= i_halt;
      if (w_halt_rise) begin
        r_page      <= PG1;
        r_halt_lock <= 1'b1;
        r_page_cnt  <= '0;
      end else if (i_page_next) begin
        r_page     <= f_next(r_page);
        r_page_cnt <= '0;
      end else if (i_auto_rotate && !r_halt_lock && w_tick) begin
        if (r_page_cnt == PG_W'(PAGE_TICKS - 1)) begin
          r_page     <= f_next(r_page);
          r_page_cnt <= '0;
        end else begin
          r_page_cnt <= r_page_cnt + PG_W'(1);
        end
      end
    end
  end

  assign o_seg_an  = r_an;
  assign o_seg_cat = r_cat;
  assign o_page    = r_page;

endmodule

`default_nettype wire
